// File: rtl/range_seq_pkg.sv
// Shared types and helpers for the range sequencer: FSM state encoding,
// parameter sanity checks and the unsigned spread (max - min) function.
package range_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_FIN  = 2'd2,
    ST_CAPT = 2'd3
  } seq_state_t;

  localparam int MAX_WIDTH = 64;
  localparam int MAX_DEPTH = 1024;

  function automatic bit width_ok(input int w);
    return (w >= 1) && (w <= MAX_WIDTH);
  endfunction

  function automatic bit depth_ok(input int d);
    return (d >= 1) && (d <= MAX_DEPTH);
  endfunction

  // Buffer index width; a single-entry buffer still needs a 1-bit address.
  function automatic int addr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] range_diff(
    input logic [MAX_WIDTH-1:0] mx,
    input logic [MAX_WIDTH-1:0] mn
  );
    return mx - mn;
  endfunction

endpackage

// File: rtl/range_sequencer_if.sv
// Host/receiver-facing signal bundle of the range sequencer. The master side
// loads samples, starts bursts and returns range_in; the slave is the sequencer.
interface range_sequencer_if
  import range_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
);
  localparam int AW = addr_w(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic [CW-1:0]    count;
  logic             busy;
  logic             go;
  logic [WIDTH-1:0] data_out;
  logic             finish;
  logic [WIDTH-1:0] range_in;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] expected;
  logic             done;
  logic             mismatch;
  logic             cmd_err;

  modport master (
    output wr_en, wr_addr, wr_data, start, count, range_in,
    input  busy, go, data_out, finish, result, expected, done, mismatch, cmd_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, count, range_in,
    output busy, go, data_out, finish, result, expected, done, mismatch, cmd_err
  );

endinterface

// File: rtl/range_sample_buf.sv
// DEPTH x WIDTH sample register file: synchronous write gated off while a
// burst is in flight, asynchronous read for the sequencer.
module range_sample_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_busy,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_gate;

  // Out-of-range addresses (non power-of-two DEPTH) are dropped.
  assign w_wr_gate = i_wr_en && !i_busy && (int'(i_wr_addr) < DEPTH);
  assign o_rd_data = r_mem[i_rd_addr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_gate) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/range_sequencer.sv
// Plays a preloaded sample burst out as go/data, strobes finish, then captures
// the receiver's range result and compares it against a locally tracked spread.
module range_sequencer
  import range_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic               clock,
  input logic               reset_n,
  range_sequencer_if.slave  bus
);

  localparam int AW = addr_w(DEPTH);

  if (!width_ok(WIDTH) || !depth_ok(DEPTH)) begin : g_param_err
    $error("range_sequencer: unsupported WIDTH or DEPTH");
  end

  seq_state_t       r_state;
  logic [CW-1:0]    r_n;
  logic [CW-1:0]    r_idx;
  logic             r_busy;
  logic             r_go;
  logic             r_finish;
  logic             r_done;
  logic             r_mismatch;
  logic             r_cmd_err;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_expected;

  logic [AW-1:0]    w_rd_addr;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_count_ok;
  logic [WIDTH-1:0] w_diff;

  range_sample_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_wr_en   (bus.wr_en),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_busy    (r_busy),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_count_ok = (bus.count != '0) && (int'(bus.count) <= DEPTH);
  assign w_diff     = WIDTH'(range_diff(MAX_WIDTH'(r_max), MAX_WIDTH'(r_min)));

  // IDLE reads entry 0 so the first sample is ready on the accepting edge;
  // r_idx reaches N after the last sample and must not index past the buffer.
  always_comb begin
    w_rd_addr = '0;
    if (r_state == ST_SEND && int'(r_idx) < DEPTH) w_rd_addr = r_idx[AW-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_n        <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_go       <= 1'b0;
      r_finish   <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_data     <= '0;
      r_max      <= '0;
      r_min      <= '0;
      r_result   <= '0;
      r_expected <= '0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (w_count_ok) begin
              r_n        <= bus.count;
              r_idx      <= CW'(1);
              r_busy     <= 1'b1;
              r_go       <= 1'b1;
              r_data     <= w_rd_data;
              r_max      <= w_rd_data;
              r_min      <= w_rd_data;
              r_mismatch <= 1'b0;
              r_state    <= ST_SEND;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (r_idx == r_n) begin
            r_go     <= 1'b0;
            r_finish <= 1'b1;
            r_state  <= ST_FIN;
          end else begin
            r_data <= w_rd_data;
            if (w_rd_data > r_max) r_max <= w_rd_data;
            if (w_rd_data < r_min) r_min <= w_rd_data;
            r_idx  <= r_idx + CW'(1);
          end
        end
        ST_FIN: begin
          r_finish <= 1'b0;
          r_state  <= ST_CAPT;
        end
        ST_CAPT: begin
          r_result   <= bus.range_in;
          r_expected <= w_diff;
          r_mismatch <= (bus.range_in != w_diff);
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.go       = r_go;
  assign bus.data_out = r_data;
  assign bus.finish   = r_finish;
  assign bus.result   = r_result;
  assign bus.expected = r_expected;
  assign bus.done     = r_done;
  assign bus.mismatch = r_mismatch;
  assign bus.cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_range_sequencer.sv
// Scoreboard bench for range_sequencer: bursts are predicted from a buffer
// model at issue time and checked by an independent negedge monitor.
module tb_range_sequencer;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] exp;
    logic             mm;
    int               fin_cyc;
    int               done_cyc;
  } txn_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  txn_t             txn_q [$];
  logic [WIDTH-1:0] samp_q [$];
  logic [WIDTH-1:0] ref_buf [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  range_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

  range_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [WIDTH-1:0] data, input bit lands);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
    if (lands) ref_buf[addr] = data;
  endtask

  // Prediction: the burst is buffer entries 0..n-1, the spread is max - min.
  task automatic start_burst(input int n, input bit force_rin, input logic [WIDTH-1:0] rin_val);
    logic [WIDTH-1:0] mx, mn, rin;
    txn_t t;
    mx = ref_buf[0];
    mn = ref_buf[0];
    for (int i = 0; i < n; i++) begin
      samp_q.push_back(ref_buf[i]);
      if (ref_buf[i] > mx) mx = ref_buf[i];
      if (ref_buf[i] < mn) mn = ref_buf[i];
    end
    t.exp      = mx - mn;
    rin        = force_rin ? rin_val : t.exp;
    t.res      = rin;
    t.mm       = (rin != t.exp);
    t.fin_cyc  = cyc + 1 + n;
    t.done_cyc = cyc + 3 + n;
    txn_q.push_back(t);
    bus.start    = 1'b1;
    bus.count    = CW'(n);
    bus.range_in = rin;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_burst();
    for (int k = 0; k < 40 && txn_q.size() != 0; k++) tick();
    if (txn_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL burst_timeout: got no done, want done within 40 cycles");
      txn_q.delete();
      samp_q.delete();
    end
  endtask

  task automatic bad_start(input int n);
    bus.start = 1'b1;
    bus.count = CW'(n);
    tick();
    bus.start = 1'b0;
    check("cmd_err_pulse", 32'(bus.cmd_err), 32'd1);
    check("cmd_err_no_go", 32'(bus.go), 32'd0);
    check("cmd_err_no_busy", 32'(bus.busy), 32'd0);
    check("cmd_err_no_fin", 32'(bus.finish), 32'd0);
    tick();
    check("cmd_err_one_cycle", 32'(bus.cmd_err), 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    txn_t t;
    if (reset_n) begin
      if (bus.go) begin
        check("go_with_finish", 32'(bus.finish), 32'd0);
        check("busy_during_go", 32'(bus.busy), 32'd1);
        check("mismatch_cleared", 32'(bus.mismatch), 32'd0);
        if (samp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_go: got go with data 0x%0h, want no go", bus.data_out);
        end else begin
          check("data_out", 32'(bus.data_out), 32'(samp_q.pop_front()));
        end
      end
      if (bus.finish) begin
        if (txn_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_finish: got finish, want none");
        end else begin
          check("finish_cycle", 32'(cyc), 32'(txn_q[0].fin_cyc));
        end
      end
      if (bus.done) begin
        if (txn_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done, want none");
        end else begin
          t = txn_q.pop_front();
          check("result", 32'(bus.result), 32'(t.res));
          check("expected", 32'(bus.expected), 32'(t.exp));
          check("mismatch", 32'(bus.mismatch), 32'(t.mm));
          check("done_cycle", 32'(cyc), 32'(t.done_cyc));
          check("busy_at_done", 32'(bus.busy), 32'd0);
          check("go_count", 32'(samp_q.size()), 32'd0);
        end
      end
    end
  end

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.start    = 1'b0;
    bus.count    = '0;
    bus.range_in = '0;
    for (int i = 0; i < DEPTH; i++) ref_buf[i] = '0;
    reset_n = 1'b0;
    repeat (3) tick();

    check("rst_go", 32'(bus.go), 32'd0);
    check("rst_finish", 32'(bus.finish), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_mismatch", 32'(bus.mismatch), 32'd0);
    check("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_expected", 32'(bus.expected), 32'd0);
    reset_n = 1'b1;
    tick();

    // Basic four-sample burst: spread 25 - 3 = 22.
    wr(0, 16'd10, 1'b1);
    wr(1, 16'd3, 1'b1);
    wr(2, 16'd25, 1'b1);
    wr(3, 16'd7, 1'b1);
    start_burst(4, 1'b0, '0);
    wait_burst();

    // Single-sample burst.
    wr(0, 16'h1234, 1'b1);
    start_burst(1, 1'b0, '0);
    wait_burst();

    bad_start(0);
    bad_start(9);

    // Receiver reports a wrong range; mismatch holds until the next start.
    wr(0, 16'd0, 1'b1);
    wr(1, 16'd100, 1'b1);
    start_burst(2, 1'b1, 16'd5);
    wait_burst();
    tick();
    check("mismatch_held", 32'(bus.mismatch), 32'd1);
    start_burst(2, 1'b0, '0);
    wait_burst();

    // Write and start issued mid-burst must be ignored.
    wr(0, 16'd11, 1'b1);
    wr(1, 16'd22, 1'b1);
    wr(2, 16'd33, 1'b1);
    wr(3, 16'd44, 1'b1);
    start_burst(4, 1'b0, '0);
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd1;
    bus.wr_data = 16'hBEEF;
    bus.start   = 1'b1;
    bus.count   = '0;
    tick();
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    check("busy_start_no_cmd_err", 32'(bus.cmd_err), 32'd0);
    wait_burst();
    start_burst(4, 1'b0, '0);
    wait_burst();

    for (int it = 0; it < 20; it++) begin
      int nw, n;
      bit frc;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++)
        wr($urandom_range(0, DEPTH - 1),
           ($urandom_range(0, 3) == 0) ? 16'hFFFF : WIDTH'($urandom), 1'b1);
      n   = $urandom_range(1, DEPTH);
      frc = ($urandom_range(0, 3) == 0);
      start_burst(n, frc, WIDTH'($urandom));
      wait_burst();
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 4; i++) wr(i, 16'(100 + i), 1'b1);
    start_burst(4, 1'b0, '0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_go", 32'(bus.go), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_finish", 32'(bus.finish), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    txn_q.delete();
    samp_q.delete();
    for (int i = 0; i < DEPTH; i++) ref_buf[i] = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    start_burst(3, 1'b0, '0);
    wait_burst();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
